// File: rtl/sd_pkg.sv
// Shared types and constants for the SPI-mode SD card initialization sequencer:
// FSM states, command selection, command encodings and failure codes.
package sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_POWERUP = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_EVAL    = 3'd4,
    ST_GAP     = 3'd5,
    ST_READY   = 3'd6,
    ST_ERROR   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    SEL_CMD0   = 3'd0,
    SEL_CMD8   = 3'd1,
    SEL_CMD55  = 3'd2,
    SEL_ACMD41 = 3'd3,
    SEL_CMD58  = 3'd4
  } cmd_sel_e;

  typedef enum logic [2:0] {
    ERR_NONE           = 3'd0,
    ERR_CMD0_FAIL      = 3'd1,
    ERR_CMD8_BAD       = 3'd2,
    ERR_ACMD41_TIMEOUT = 3'd3,
    ERR_R1_REJECT      = 3'd4,
    ERR_CMD58_FAIL     = 3'd5,
    ERR_RESP_TIMEOUT   = 3'd6
  } err_e;

  localparam logic [5:0] CMD0_IDX   = 6'd0;
  localparam logic [5:0] CMD8_IDX   = 6'd8;
  localparam logic [5:0] CMD55_IDX  = 6'd55;
  localparam logic [5:0] ACMD41_IDX = 6'd41;
  localparam logic [5:0] CMD58_IDX  = 6'd58;

  localparam logic [6:0] CRC_CMD0      = 7'h4A;
  localparam logic [6:0] CRC_CMD8      = 7'h43;
  localparam logic [6:0] CRC_CMD55     = 7'h32;
  localparam logic [6:0] CRC_ACMD41_V2 = 7'h3B;
  localparam logic [6:0] CRC_ACMD41_V1 = 7'h72;
  localparam logic [6:0] CRC_CMD58     = 7'h7E;

  localparam logic [31:0] CMD8_ARG       = 32'h0000_01AA;
  localparam logic [31:0] ACMD41_ARG_HCS = 32'h4000_0000;

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [6:0]  crc;
    logic        long_resp;  // 5-byte R3/R7 response instead of bare R1
  } cmd_word_t;

  function automatic cmd_word_t encode_cmd(input cmd_sel_e sel, input logic v2);
    cmd_word_t w;
    w = '{idx: CMD0_IDX, arg: 32'h0, crc: CRC_CMD0, long_resp: 1'b0};
    unique case (sel)
      SEL_CMD0:   w = '{idx: CMD0_IDX,  arg: 32'h0,    crc: CRC_CMD0,  long_resp: 1'b0};
      SEL_CMD8:   w = '{idx: CMD8_IDX,  arg: CMD8_ARG, crc: CRC_CMD8,  long_resp: 1'b1};
      SEL_CMD55:  w = '{idx: CMD55_IDX, arg: 32'h0,    crc: CRC_CMD55, long_resp: 1'b0};
      SEL_ACMD41: w = '{idx: ACMD41_IDX,
                        arg: v2 ? ACMD41_ARG_HCS : 32'h0,
                        crc: v2 ? CRC_ACMD41_V2 : CRC_ACMD41_V1,
                        long_resp: 1'b0};
      SEL_CMD58:  w = '{idx: CMD58_IDX, arg: 32'h0,    crc: CRC_CMD58, long_resp: 1'b1};
      default:    w = '{idx: CMD0_IDX,  arg: 32'h0,    crc: CRC_CMD0,  long_resp: 1'b0};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sd_init_sequencer_if.sv
// Request/response bundle between the init sequencer (master) and the
// single-command SD command controller (slave).
// Handshake: master holds cmd/arg/crc/nresponse stable and pulses cmd_start for
// one cycle; slave answers with a one-cycle cmd_done carrying r1 (and r_tail for
// 5-byte responses). There is no backpressure; one command is in flight at a time.
interface sd_init_sequencer_if #(
  parameter int MEMORY_SIZE_IN_BYTES = 64
);
  localparam int NRW = $clog2(MEMORY_SIZE_IN_BYTES);

  logic [5:0]     cmd;
  logic [31:0]    arg;
  logic [6:0]     crc;
  logic [NRW-1:0] nresponse;
  logic           cmd_start;
  logic           cmd_done;
  logic [7:0]     r1;
  logic [31:0]    r_tail;

  modport master (
    output cmd, arg, crc, nresponse, cmd_start,
    input  cmd_done, r1, r_tail
  );

  modport slave (
    input  cmd, arg, crc, nresponse, cmd_start,
    output cmd_done, r1, r_tail
  );
endinterface

// File: rtl/sd_cycle_timer.sv
// Loadable down-counter; expired_o is high while the count sits at zero, so a
// load of N-1 makes the owning state last exactly N cycles.
module sd_cycle_timer #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_value_i,
  output logic [W-1:0] value_o,
  output logic         expired_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign value_o   = count_q;
  assign expired_o = (count_q == '0);

endmodule

// File: rtl/sd_init_sequencer.sv
// SPI-mode SD card init sequencer: CMD0, CMD8, CMD55/ACMD41 polling, CMD58,
// issued one at a time through the command controller bundle.
module sd_init_sequencer
  import sd_pkg::*;
#(
  parameter int MEMORY_SIZE_IN_BYTES = 64,
  parameter int POWERUP_CYCLES       = 4096,
  parameter int CMD0_RETRIES         = 8,
  parameter int ACMD41_RETRIES       = 1024,
  parameter int POLL_GAP_CYCLES      = 256,
  parameter int RESP_TIMEOUT_CYCLES  = 65536
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init_start,
  sd_init_sequencer_if.master bus,
  output logic                busy,
  output logic                ready,
  output logic                error,
  output logic [2:0]          err_code,
  output logic                card_v2,
  output logic                card_hc,
  output logic [2:0]          dbg_state
);

  localparam int NRW = $clog2(MEMORY_SIZE_IN_BYTES);
  localparam int TW  = $clog2(RESP_TIMEOUT_CYCLES + POWERUP_CYCLES + POLL_GAP_CYCLES + 1);
  localparam int RW  = $clog2(CMD0_RETRIES + ACMD41_RETRIES + 1);

  state_e         state_q, state_d;
  cmd_sel_e       cur_cmd_q, cur_cmd_d;
  err_e           err_q, err_d;
  logic [RW-1:0]  retry_q, retry_d;
  logic           v2_q, v2_d;
  logic           hc_q, hc_d;
  logic [7:0]     r1_q, r1_d;
  logic [31:0]    tail_q, tail_d;
  logic           start_q, start_d;
  logic [5:0]     cmd_q;
  logic [31:0]    arg_q;
  logic [6:0]     crc_q;
  logic [NRW-1:0] nresp_q;

  logic           t_load;
  logic [TW-1:0]  t_value;
  logic [TW-1:0]  timer_value;
  logic           t_expired;
  cmd_word_t      next_word;

  // One timer serves POWERUP, WAIT and GAP; each state loads it on entry.
  sd_cycle_timer #(.W(TW)) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (t_load),
    .load_value_i (t_value),
    .value_o      (timer_value),
    .expired_o    (t_expired)
  );

  always_comb begin
    state_d   = state_q;
    cur_cmd_d = cur_cmd_q;
    err_d     = err_q;
    retry_d   = retry_q;
    v2_d      = v2_q;
    hc_d      = hc_q;
    r1_d      = r1_q;
    tail_d    = tail_q;
    start_d   = 1'b0;
    t_load    = 1'b0;
    t_value   = '0;
    unique case (state_q)
      ST_IDLE, ST_READY, ST_ERROR: begin
        if (init_start) begin
          state_d = ST_POWERUP;
          err_d   = ERR_NONE;
          retry_d = '0;
          v2_d    = 1'b0;
          hc_d    = 1'b0;
          t_load  = 1'b1;
          t_value = TW'(POWERUP_CYCLES - 1);
        end
      end
      ST_POWERUP: begin
        if (t_expired) begin
          cur_cmd_d = SEL_CMD0;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        start_d = 1'b1;
        t_load  = 1'b1;
        t_value = TW'(RESP_TIMEOUT_CYCLES - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A response arriving in the expiry cycle still counts.
        if (bus.cmd_done) begin
          r1_d    = bus.r1;
          tail_d  = bus.r_tail;
          state_d = ST_EVAL;
        end else if (t_expired) begin
          err_d   = ERR_RESP_TIMEOUT;
          state_d = ST_ERROR;
        end
      end
      ST_EVAL: begin
        unique case (cur_cmd_q)
          SEL_CMD0: begin
            if (r1_q == 8'h01) begin
              retry_d   = '0;
              cur_cmd_d = SEL_CMD8;
              state_d   = ST_ISSUE;
            end else if (retry_q >= RW'(CMD0_RETRIES - 1)) begin
              err_d   = ERR_CMD0_FAIL;
              state_d = ST_ERROR;
            end else begin
              retry_d = retry_q + 1'b1;
              state_d = ST_ISSUE;
            end
          end
          SEL_CMD8: begin
            if (r1_q == 8'h01 && tail_q[11:0] == 12'h1AA) begin
              v2_d      = 1'b1;
              cur_cmd_d = SEL_CMD55;
              state_d   = ST_ISSUE;
            end else if (r1_q[2]) begin
              v2_d      = 1'b0;
              cur_cmd_d = SEL_CMD55;
              state_d   = ST_ISSUE;
            end else begin
              err_d   = ERR_CMD8_BAD;
              state_d = ST_ERROR;
            end
          end
          SEL_CMD55: begin
            if (r1_q[7:1] == 7'd0) begin
              cur_cmd_d = SEL_ACMD41;
              state_d   = ST_ISSUE;
            end else begin
              err_d   = ERR_R1_REJECT;
              state_d = ST_ERROR;
            end
          end
          SEL_ACMD41: begin
            if (r1_q == 8'h00) begin
              if (v2_q) begin
                cur_cmd_d = SEL_CMD58;
                state_d   = ST_ISSUE;
              end else begin
                state_d = ST_READY;
              end
            end else if (r1_q == 8'h01) begin
              if (retry_q >= RW'(ACMD41_RETRIES - 1)) begin
                err_d   = ERR_ACMD41_TIMEOUT;
                state_d = ST_ERROR;
              end else begin
                retry_d = retry_q + 1'b1;
                t_load  = 1'b1;
                t_value = TW'(POLL_GAP_CYCLES - 1);
                state_d = ST_GAP;
              end
            end else begin
              err_d   = ERR_R1_REJECT;
              state_d = ST_ERROR;
            end
          end
          SEL_CMD58: begin
            if (r1_q == 8'h00) begin
              hc_d    = tail_q[30];
              state_d = ST_READY;
            end else begin
              err_d   = ERR_CMD58_FAIL;
              state_d = ST_ERROR;
            end
          end
          default: begin
            err_d   = ERR_R1_REJECT;
            state_d = ST_ERROR;
          end
        endcase
      end
      ST_GAP: begin
        if (t_expired) begin
          cur_cmd_d = SEL_CMD55;
          state_d   = ST_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign next_word = encode_cmd(cur_cmd_d, v2_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cur_cmd_q <= SEL_CMD0;
      err_q     <= ERR_NONE;
      retry_q   <= '0;
      v2_q      <= 1'b0;
      hc_q      <= 1'b0;
      r1_q      <= '0;
      tail_q    <= '0;
      start_q   <= 1'b0;
      cmd_q     <= '0;
      arg_q     <= '0;
      crc_q     <= '0;
      nresp_q   <= '0;
    end else begin
      state_q   <= state_d;
      cur_cmd_q <= cur_cmd_d;
      err_q     <= err_d;
      retry_q   <= retry_d;
      v2_q      <= v2_d;
      hc_q      <= hc_d;
      r1_q      <= r1_d;
      tail_q    <= tail_d;
      start_q   <= start_d;
      // Command fields settle on ISSUE entry and hold until the next ISSUE.
      if (state_d == ST_ISSUE) begin
        cmd_q   <= next_word.idx;
        arg_q   <= next_word.arg;
        crc_q   <= next_word.crc;
        nresp_q <= next_word.long_resp ? NRW'(4) : '0;
      end
    end
  end

  assign bus.cmd       = cmd_q;
  assign bus.arg       = arg_q;
  assign bus.crc       = crc_q;
  assign bus.nresponse = nresp_q;
  assign bus.cmd_start = start_q;

  assign busy      = (state_q == ST_POWERUP) || (state_q == ST_ISSUE) || (state_q == ST_WAIT) ||
                     (state_q == ST_EVAL) || (state_q == ST_GAP);
  assign ready     = (state_q == ST_READY);
  assign error     = (state_q == ST_ERROR);
  assign err_code  = err_q;
  assign card_v2   = v2_q;
  assign card_hc   = hc_q;
  assign dbg_state = state_q;

  logic unused_ok;
  assign unused_ok = ^{tail_q[31], tail_q[29:12], timer_value};

endmodule

// File: doc/sd_init_sequencer.md
# sd_init_sequencer

Sequences the SPI-mode SD card power-up and initialization flow (CMD0, CMD8, CMD55/ACMD41 polling, CMD58) by driving the single-command SD command controller one command at a time. It sits between system bring-up logic and the command controller, evaluates each R1/R3/R7 response, and reports card version, capacity class and a ready/error status. It owns the command controller's request inputs while initialization runs.

## Interface
- MEMORY_SIZE_IN_BYTES, 64, sizes nresponse to match the command controller's transfer-size field.
- POWERUP_CYCLES, 4096, clk cycles waited after init_start before CMD0.
- CMD0_RETRIES, 8, max CMD0 attempts.
- ACMD41_RETRIES, 1024, max ACMD41 attempts returning idle (R1 = 0x01).
- POLL_GAP_CYCLES, 256, clk cycles between an idle ACMD41 response and the next CMD55.
- RESP_TIMEOUT_CYCLES, 65536, max clk cycles from cmd_start to cmd_done.
- Reset is rst_n, asynchronous, active-low; clock is clk.
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- init_start  input  1  start/restart request, level-sampled.
- cmd  output  6  command index to controller.
- arg  output  32  command argument.
- crc  output  7  CRC7 (controller appends end bit).
- nresponse  output  $clog2(MEMORY_SIZE_IN_BYTES)  response length minus one (0 = 1 byte R1, 4 = 5-byte R3/R7).
- cmd_start  output  1  one-cycle command request pulse.
- cmd_done  input  1  one-cycle command completion pulse.
- r1  input  8  first response byte, valid when cmd_done is high.
- r_tail  input  32  response bytes 2..5 (big-endian), valid with cmd_done when nresponse = 4.
- busy  output  1  initialization in progress.
- ready  output  1  card initialized.
- error  output  1  initialization failed.
- err_code  output  3  failure cause, valid while error is high.
- card_v2  output  1  card accepted CMD8 (v2.00+).
- card_hc  output  1  CCS bit from CMD58 (SDHC/SDXC block addressing).

## Operation
- States: IDLE, POWERUP, ISSUE, WAIT, EVAL, GAP, READY, ERROR. A register cur_cmd (CMD0, CMD8, CMD55, ACMD41, CMD58) selects the cmd/arg/crc/nresponse values.
- Command values: CMD0 arg 0, crc 7'h4A, nresponse 0; CMD8 arg 32'h000001AA, crc 7'h43, nresponse 4; CMD55 arg 0, crc 7'h32, nresponse 0; ACMD41 (index 41) arg 32'h40000000 if card_v2 else 0, crc 7'h3B if card_v2 else 7'h72, nresponse 0; CMD58 arg 0, crc 7'h7E, nresponse 4.
- IDLE/READY/ERROR + init_start: clear flags, counters and err_code, go to POWERUP. Ignore init_start in all other states.
- POWERUP: count POWERUP_CYCLES, then cur_cmd = CMD0, go to ISSUE.
- ISSUE: pulse cmd_start, load the response timer, go to WAIT.
- WAIT: on cmd_done, latch r1/r_tail and go to EVAL. On timer expiry go to ERROR with code 6.
- EVAL, CMD0:
  - r1 = 0x01 goes to CMD8.
  - Otherwise retry while attempts < CMD0_RETRIES; when exhausted, ERROR code 1.
- EVAL, CMD8:
  - r1 = 0x01 and r_tail[11:0] = 12'h1AA sets card_v2 = 1 and goes to CMD55.
  - r1 bit 2 set (illegal command) sets card_v2 = 0 and goes to CMD55.
  - Otherwise ERROR code 2.
- EVAL, CMD55: r1[7:1] = 0 goes to ACMD41. Otherwise ERROR code 4.
- EVAL, ACMD41:
  - r1 = 0x00 goes to CMD58 if card_v2, else to READY.
  - r1 = 0x01 increments the attempt count and goes to GAP; when the count reaches ACMD41_RETRIES, ERROR code 3.
  - Any other value is ERROR code 4.
- EVAL, CMD58: r1 = 0x00 sets card_hc = r_tail[30] and goes to READY. Otherwise ERROR code 5.
- GAP: wait POLL_GAP_CYCLES, then cur_cmd = CMD55, go to ISSUE.
- busy = 1 in POWERUP, ISSUE, WAIT, EVAL and GAP. ready = 1 only in READY. error = 1 only in ERROR.
- A cmd_done outside WAIT is ignored.

## Timing
- Reset values: all outputs 0, state IDLE.
- init_start high in cycle N: busy is high in N+1.
- cmd_start is high for exactly one cycle, in the cycle after entering ISSUE.
- cmd, arg, crc and nresponse are registered and stable from one cycle before cmd_start through the cycle of cmd_done.
- Per command, the minimum cycles from cmd_done to the next cmd_start is 3 (WAIT→EVAL→ISSUE→pulse).
- Timers are loadable down-counters. Expiry is the cycle the count reaches 0, exactly N cycles after load.
- Timeout versus response in the same cycle: a cmd_done in the expiry cycle wins.
- Retry counters saturate and never wrap.
- rst_n asserted mid-operation: immediate return to IDLE with all outputs 0. The command controller must be reset alongside.

## Structure
- Package sd_pkg holds:
  - state enum;
  - command index constants (CMD0 = 0, CMD8 = 8, CMD55 = 55, ACMD41 = 41, CMD58 = 58);
  - CRC7 constants;
  - err_code enum (1 CMD0_FAIL, 2 CMD8_BAD, 3 ACMD41_TIMEOUT, 4 R1_REJECT, 5 CMD58_FAIL, 6 RESP_TIMEOUT).
- Sub-module sd_cycle_timer: a loadable down-counter with load, value and expired outputs. Instantiate it once, shared by POWERUP, GAP and WAIT, which never overlap.

## Test plan
- v2 SDHC card:
  - Stimulus: CMD0→0x01; CMD8→0x01 with r_tail 0x000001AA; ACMD41 returns 0x01 twice then 0x00; CMD58→0x00 with r_tail 0xC0FF8000.
  - Required: ready = 1, card_v2 = 1, card_hc = 1, exactly 9 cmd_start pulses.
- v1 card: CMD8 r1 = 0x05, ACMD41→0x00 first try → ready = 1, card_v2 = 0, ACMD41 arg 0, no CMD58 issued.
- CMD0 always 0xFF with CMD0_RETRIES = 8 → 8 CMD0 pulses, then error = 1 with err_code 1.
- ACMD41 always 0x01 with ACMD41_RETRIES = 4 → error with err_code 3. Every CMD55 follows the prior ACMD41 cmd_done by POLL_GAP_CYCLES + 3 cycles.
- cmd_done withheld after CMD8 with RESP_TIMEOUT_CYCLES = 16 → error with err_code 6, 16 cycles after cmd_start. Then a subsequent init_start restarts: busy high, error low.
- rst_n pulsed during ACMD41 polling → all outputs 0 within the same cycle; init_start is ignored while busy.
